// File: rtl/mem_access_controller_if.sv
// Memory handshake bundle: control-unit MFA/MFC request side plus the byte-wide RAM port.
// MisAlign exists only when MISALIGN_CHECK_EN is defined.
interface mem_access_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  MFA;
   logic                  RW;
   logic [1:0]            TYPE;
   logic [ADDR_WIDTH-1:0] ADDR;
   logic [31:0]           DataIn;
   logic [31:0]           DataOut;
   logic                  MFC;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;
   logic                  mem_we;
   logic [7:0]            mem_rdata;
`ifdef MISALIGN_CHECK_EN
   logic                  MisAlign;
`endif

   modport slave (
      input  MFA, RW, TYPE, ADDR, DataIn, mem_rdata,
`ifdef MISALIGN_CHECK_EN
      output MisAlign,
`endif
      output DataOut, MFC, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output MFA, RW, TYPE, ADDR, DataIn, mem_rdata,
`ifdef MISALIGN_CHECK_EN
      input  MisAlign,
`endif
      input  DataOut, MFC, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/mem_access_controller.sv
// Splits word/halfword/byte MFA requests into big-endian single-byte RAM accesses with optional wait states.
// Optional MISALIGN_CHECK_EN rejects unaligned halfword/word requests without touching RAM.
module mem_access_controller #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_STATES = 0
) (
   input logic        CLK,
   input logic        Reset,
   mem_access_if.slave bus
);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [1:0]            type_reg;
   logic                  rw_reg;
   logic [31:0]           data_reg;
   logic [31:0]           dout_reg;
   logic [1:0]            idx_reg;
   logic [3:0]            wcnt_reg;
   logic                  mfc_reg;
`ifdef MISALIGN_CHECK_EN
   logic                  misalign_reg;
`endif

   logic       xfer;
   logic       last;
   logic       misaligned;
   logic [1:0] last_idx;
   logic [1:0] lane;

   // Offset k lands in lane N-1-k, so the lowest address carries the most significant byte.
   assign last_idx = (type_reg == 2'b00) ? 2'd0 : (type_reg == 2'b01) ? 2'd1 : 2'd3;
   assign lane     = last_idx - idx_reg;
   assign last     = (idx_reg == last_idx);
   assign xfer     = (state_reg == ACCESS) && (wcnt_reg == WS);

`ifdef MISALIGN_CHECK_EN
   assign misaligned = ((bus.TYPE == 2'b01) && bus.ADDR[0]) ||
                       (bus.TYPE[1] && (bus.ADDR[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.MFA) state_next = misaligned ? DONE : ACCESS;
         ACCESS:  if (xfer && last) state_next = DONE;
         DONE:    if (!bus.MFA) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         type_reg     <= 2'b00;
         rw_reg       <= 1'b0;
         data_reg     <= 32'h0;
         dout_reg     <= 32'h0;
         idx_reg      <= 2'd0;
         wcnt_reg     <= 4'd0;
         mfc_reg      <= 1'b0;
`ifdef MISALIGN_CHECK_EN
         misalign_reg <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (bus.MFA) begin
                  addr_reg <= bus.ADDR;
                  type_reg <= bus.TYPE;
                  rw_reg   <= bus.RW;
                  data_reg <= bus.DataIn;
                  idx_reg  <= 2'd0;
                  wcnt_reg <= 4'd0;
                  dout_reg <= 32'h0;
                  if (misaligned) begin
                     mfc_reg      <= 1'b1;
`ifdef MISALIGN_CHECK_EN
                     misalign_reg <= 1'b1;
`endif
                  end
               end
            end
            ACCESS: begin
               if (wcnt_reg != WS) begin
                  wcnt_reg <= wcnt_reg + 4'd1;
               end else begin
                  wcnt_reg <= 4'd0;
                  idx_reg  <= idx_reg + 2'd1;
                  if (!rw_reg) dout_reg[{lane, 3'b000} +: 8] <= bus.mem_rdata;
                  if (last) mfc_reg <= 1'b1;
               end
            end
            DONE: begin
               if (!bus.MFA) begin
                  mfc_reg      <= 1'b0;
`ifdef MISALIGN_CHECK_EN
                  misalign_reg <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // RAM port is parked at zero outside ACCESS so nothing moves while idle or done.
   assign bus.mem_addr  = (state_reg == ACCESS) ? addr_reg + ADDR_WIDTH'(idx_reg) : '0;
   assign bus.mem_wdata = (state_reg == ACCESS) ? data_reg[{lane, 3'b000} +: 8] : 8'h00;
   assign bus.mem_we    = xfer && rw_reg;
   assign bus.DataOut   = dout_reg;
   assign bus.MFC       = mfc_reg;
`ifdef MISALIGN_CHECK_EN
   assign bus.MisAlign  = misalign_reg;
`endif
endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: one zero-wait-state instance and one with two wait states,
// each backed by a 256-byte RAM model.
module tb_mem_access_controller;
   logic CLK   = 1'b0;
   logic Reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 CLK = ~CLK;

   mem_access_if #(.ADDR_WIDTH(8)) bus0 ();
   mem_access_if #(.ADDR_WIDTH(8)) bus2 ();

   mem_access_controller #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
      .CLK(CLK), .Reset(Reset), .bus(bus0.slave));
   mem_access_controller #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut2 (
      .CLK(CLK), .Reset(Reset), .bus(bus2.slave));

   logic [7:0] ram0 [0:255];
   logic [7:0] ram2 [0:255];
   int we_cnt0   = 0;
   int mfc_rise0 = 0;

   assign bus0.mem_rdata = ram0[bus0.mem_addr];
   assign bus2.mem_rdata = ram2[bus2.mem_addr];

   always @(posedge CLK) begin
      if (bus0.mem_we === 1'b1) begin
         ram0[bus0.mem_addr] <= bus0.mem_wdata;
         we_cnt0 <= we_cnt0 + 1;
      end
      if (bus2.mem_we === 1'b1) ram2[bus2.mem_addr] <= bus2.mem_wdata;
   end

   always @(posedge bus0.MFC) mfc_rise0 <= mfc_rise0 + 1;

   task automatic req0(input logic rw, input logic [1:0] ty, input logic [7:0] a, input logic [31:0] d);
      bus0.RW = rw; bus0.TYPE = ty; bus0.ADDR = a; bus0.DataIn = d; bus0.MFA = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic req2(input logic rw, input logic [1:0] ty, input logic [7:0] a, input logic [31:0] d);
      bus2.RW = rw; bus2.TYPE = ty; bus2.ADDR = a; bus2.DataIn = d; bus2.MFA = 1'b1;
      @(posedge CLK); #1;
   endtask

   task automatic release0();
      bus0.MFA = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (bus0.DataOut !== 32'h0) begin errors++; $display("FAIL reset_dataout: got %h, expected 00000000", bus0.DataOut); end
      checks++; if (bus0.MFC !== 1'b0) begin errors++; $display("FAIL reset_mfc: got %b, expected 0", bus0.MFC); end
      checks++; if (bus0.mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, expected 0", bus0.mem_we); end
      checks++; if (bus0.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h, expected 00", bus0.mem_addr); end
      checks++; if (bus0.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h, expected 00", bus0.mem_wdata); end
      checks++; if (bus2.MFC !== 1'b0) begin errors++; $display("FAIL reset_mfc_ws2: got %b, expected 0", bus2.MFC); end
      Reset = 1'b0;
      $display("reset released");
   endtask

   task automatic test_word_read();
      int k;
      ram0[8'h10] <= 8'hDE; ram0[8'h11] <= 8'hAD; ram0[8'h12] <= 8'hBE; ram0[8'h13] <= 8'hEF;
      req0(1'b0, 2'b10, 8'h10, 32'h0);
      k = 0;
      while (bus0.MFC !== 1'b1 && k < 20) begin @(posedge CLK); #1; k++; end
      checks++; if (k !== 4) begin errors++; $display("FAIL word_read_latency: got %0d edges, expected 4", k); end
      checks++; if (bus0.DataOut !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read_data: got %h, expected deadbeef", bus0.DataOut); end
      release0();
      checks++; if (bus0.MFC !== 1'b0) begin errors++; $display("FAIL word_read_mfc_clear: got %b, expected 0", bus0.MFC); end
      $display("word read 0x10 -> %h after %0d edges", bus0.DataOut, k);
   endtask

   task automatic test_word_write();
      int k;
      int base;
      logic [7:0] exp [4];
      exp = '{8'h12, 8'h34, 8'h56, 8'h78};
      base = we_cnt0;
      req0(1'b1, 2'b10, 8'h20, 32'h12345678);
      k = 0;
      while (bus0.MFC !== 1'b1 && k < 20) begin @(posedge CLK); #1; k++; end
      checks++; if (k !== 4) begin errors++; $display("FAIL word_write_latency: got %0d edges, expected 4", k); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (ram0[8'h20 + i] !== exp[i]) begin
            errors++; $display("FAIL word_write_ram[%0d]: got %h, expected %h", i, ram0[8'h20 + i], exp[i]);
         end
      end
      checks++; if (we_cnt0 - base !== 4) begin errors++; $display("FAIL word_write_we_pulses: got %0d, expected 4", we_cnt0 - base); end
      release0();
      req0(1'b0, 2'b00, 8'h22, 32'hFFFFFFFF);
      k = 0;
      while (bus0.MFC !== 1'b1 && k < 20) begin @(posedge CLK); #1; k++; end
      checks++; if (k !== 1) begin errors++; $display("FAIL byte_read_latency: got %0d edges, expected 1", k); end
      checks++; if (bus0.DataOut !== 32'h00000056) begin errors++; $display("FAIL byte_read_data: got %h, expected 00000056", bus0.DataOut); end
      release0();
      $display("word write 0x20 then byte read 0x22 -> %h", bus0.DataOut);
   endtask

`ifndef MISALIGN_CHECK_EN
   task automatic test_wrap_halfword();
      ram0[8'hFF] <= 8'hAB; ram0[8'h00] <= 8'hCD;
      req0(1'b0, 2'b01, 8'hFF, 32'h0);
      checks++; if (bus0.mem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_addr0: got %h, expected ff", bus0.mem_addr); end
      @(posedge CLK); #1;
      checks++; if (bus0.mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr1: got %h, expected 00", bus0.mem_addr); end
      checks++; if (bus0.MFC !== 1'b0) begin errors++; $display("FAIL wrap_mfc_early: got %b, expected 0", bus0.MFC); end
      @(posedge CLK); #1;
      checks++; if (bus0.MFC !== 1'b1) begin errors++; $display("FAIL wrap_mfc: got %b, expected 1", bus0.MFC); end
      checks++; if (bus0.DataOut !== 32'h0000ABCD) begin errors++; $display("FAIL wrap_data: got %h, expected 0000abcd", bus0.DataOut); end
      release0();
      $display("halfword read 0xff wrap -> %h", bus0.DataOut);
   endtask
`endif

   task automatic test_wait_states();
      int k;
      logic [7:0] addr_done;
      ram2[8'h05] <= 8'h77;
      req2(1'b0, 2'b00, 8'h05, 32'h0);
      k = 0;
      while (bus2.MFC !== 1'b1 && k < 20) begin @(posedge CLK); #1; k++; end
      checks++; if (k !== 3) begin errors++; $display("FAIL ws_latency: got %0d edges, expected 3", k); end
      checks++; if (bus2.DataOut !== 32'h00000077) begin errors++; $display("FAIL ws_data: got %h, expected 00000077", bus2.DataOut); end
      addr_done = bus2.mem_addr;
      for (int i = 0; i < 5; i++) begin
         @(posedge CLK); #1;
         checks++;
         if (bus2.MFC !== 1'b1 || bus2.mem_addr !== addr_done || bus2.mem_we !== 1'b0 || bus2.DataOut !== 32'h77) begin
            errors++;
            $display("FAIL ws_hold[%0d]: got mfc=%b addr=%h we=%b data=%h, expected mfc=1 addr=%h we=0 data=00000077",
                     i, bus2.MFC, bus2.mem_addr, bus2.mem_we, bus2.DataOut, addr_done);
         end
      end
      bus2.MFA = 1'b0;
      @(posedge CLK); #1;
      checks++; if (bus2.MFC !== 1'b0) begin errors++; $display("FAIL ws_mfc_clear: got %b, expected 0", bus2.MFC); end
      $display("wait-state byte read 0x05 -> %h after %0d edges", bus2.DataOut, k);
   endtask

   task automatic test_mfa_drop();
      int k;
      req0(1'b0, 2'b10, 8'h10, 32'h0);
      bus0.MFA = 1'b0;
      k = 0;
      while (bus0.MFC !== 1'b1 && k < 20) begin @(posedge CLK); #1; k++; end
      checks++; if (k !== 4) begin errors++; $display("FAIL mfa_drop_latency: got %0d edges, expected 4", k); end
      checks++; if (bus0.DataOut !== 32'hDEADBEEF) begin errors++; $display("FAIL mfa_drop_data: got %h, expected deadbeef", bus0.DataOut); end
      @(posedge CLK); #1;
      checks++; if (bus0.MFC !== 1'b0) begin errors++; $display("FAIL mfa_drop_done_len: got %b, expected 0", bus0.MFC); end
      $display("word read with early MFA drop -> %h", bus0.DataOut);
   endtask

   task automatic test_reset_abort();
      int rise;
      ram0[8'h40] <= 8'h00; ram0[8'h41] <= 8'h00; ram0[8'h42] <= 8'h00; ram0[8'h43] <= 8'h00;
      rise = mfc_rise0;
      req0(1'b1, 2'b10, 8'h40, 32'hA1B2C3D4);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      Reset = 1'b1;
      #1;
      checks++; if (bus0.mem_we !== 1'b0) begin errors++; $display("FAIL abort_we: got %b, expected 0", bus0.mem_we); end
      checks++; if (bus0.mem_addr !== 8'h00) begin errors++; $display("FAIL abort_addr: got %h, expected 00", bus0.mem_addr); end
      checks++; if (bus0.mem_wdata !== 8'h00) begin errors++; $display("FAIL abort_wdata: got %h, expected 00", bus0.mem_wdata); end
      checks++; if (bus0.DataOut !== 32'h0) begin errors++; $display("FAIL abort_dataout: got %h, expected 00000000", bus0.DataOut); end
      bus0.MFA = 1'b0;
      repeat (2) @(posedge CLK);
      #1 Reset = 1'b0;
      @(posedge CLK); #1;
      checks++;
      if (ram0[8'h40] !== 8'hA1 || ram0[8'h41] !== 8'hB2 || ram0[8'h42] !== 8'h00 || ram0[8'h43] !== 8'h00) begin
         errors++;
         $display("FAIL abort_ram: got %h %h %h %h, expected a1 b2 00 00", ram0[8'h40], ram0[8'h41], ram0[8'h42], ram0[8'h43]);
      end
      checks++; if (mfc_rise0 !== rise) begin errors++; $display("FAIL abort_mfc_pulse: got %0d rises, expected 0", mfc_rise0 - rise); end
      checks++; if (bus0.MFC !== 1'b0) begin errors++; $display("FAIL abort_mfc: got %b, expected 0", bus0.MFC); end
      $display("reset abort of word write 0x40 -> ram %h %h %h %h", ram0[8'h40], ram0[8'h41], ram0[8'h42], ram0[8'h43]);
   endtask

`ifdef MISALIGN_CHECK_EN
   task automatic test_misalign();
      int base;
      base = we_cnt0;
      req0(1'b0, 2'b10, 8'h02, 32'h0);
      checks++; if (bus0.MFC !== 1'b1) begin errors++; $display("FAIL misalign_mfc: got %b, expected 1", bus0.MFC); end
      checks++; if (bus0.MisAlign !== 1'b1) begin errors++; $display("FAIL misalign_flag: got %b, expected 1", bus0.MisAlign); end
      checks++; if (bus0.DataOut !== 32'h0) begin errors++; $display("FAIL misalign_data: got %h, expected 00000000", bus0.DataOut); end
      release0();
      checks++; if (bus0.MisAlign !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b, expected 0", bus0.MisAlign); end
      req0(1'b1, 2'b01, 8'hFF, 32'h0000BEEF);
      checks++; if (bus0.MisAlign !== 1'b1) begin errors++; $display("FAIL misalign_half_flag: got %b, expected 1", bus0.MisAlign); end
      release0();
      checks++; if (we_cnt0 - base !== 0) begin errors++; $display("FAIL misalign_we: got %0d pulses, expected 0", we_cnt0 - base); end
      $display("misaligned word read 0x02 and halfword write 0xff rejected");
   endtask
`endif

   initial begin
      bus0.MFA = 1'b0; bus0.RW = 1'b0; bus0.TYPE = 2'b00; bus0.ADDR = 8'h00; bus0.DataIn = 32'h0;
      bus2.MFA = 1'b0; bus2.RW = 1'b0; bus2.TYPE = 2'b00; bus2.ADDR = 8'h00; bus2.DataIn = 32'h0;
      test_reset();
      @(posedge CLK); #1;
      test_word_read();
      test_word_write();
`ifndef MISALIGN_CHECK_EN
      test_wrap_halfword();
`endif
      test_wait_states();
      test_mfa_drop();
      test_reset_abort();
`ifdef MISALIGN_CHECK_EN
      test_misalign();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Sits between the data path's MFA/MFC memory handshake and the byte-wide RAM array.
- Turns one word, halfword or byte request into a sequence of single-byte accesses.
- Assembles and splits data big-endian (lowest address = most significant byte).
- Asserts MFC once the whole transfer is complete; optional wait states model slow memory.

Parameters:
ADDR_WIDTH, 8, byte address width; the address space is 2^ADDR_WIDTH bytes.
WAIT_STATES, 0, extra idle cycles inserted before each byte transfer (0..15).

Ports:
CLK  input  1  clock; all state changes on the rising edge.
Reset  input  1  asynchronous, active-high reset.
MFA  input  1  memory function active; request strobe from the control unit.
RW  input  1  1 = write, 0 = read.
TYPE  input  2  transfer size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
ADDR  input  ADDR_WIDTH  start byte address.
DataIn  input  32  write data.
DataOut  output  32  read data, zero-extended for byte and halfword transfers.
MFC  output  1  memory function complete.
mem_addr  output  ADDR_WIDTH  byte address to the RAM.
mem_wdata  output  8  byte write data.
mem_we  output  1  RAM write strobe; the RAM writes on the rising edge while this is high.
mem_rdata  input  8  RAM read data, combinational from mem_addr.

Behaviour:
- Reset values (asynchronous): state IDLE, DataOut=0, MFC=0, mem_we=0, mem_addr=0, mem_wdata=0, all counters 0.
- Byte count N: 1 for byte, 2 for halfword, 4 for word and for TYPE 11.
- IDLE:
  - MFA is sampled high on a rising edge.
  - ADDR, TYPE, RW and DataIn are latched, and the state moves to ACCESS with idx=0 and wcnt=0.
- ACCESS:
  - mem_addr = (latched ADDR + idx) mod 2^ADDR_WIDTH.
  - Each edge with wcnt<WAIT_STATES increments wcnt.
  - The edge with wcnt==WAIT_STATES is the transfer edge: it transfers byte idx, clears wcnt and increments idx.
  - mem_we = RW and (wcnt==WAIT_STATES), combinational; it is never high outside ACCESS.
- Byte lane mapping: the byte at offset k maps to data bits [8(N-1-k)+7 : 8(N-1-k)].
  - Word: offset 0 maps to [31:24].
  - Halfword: offset 0 maps to [15:8], offset 1 to [7:0].
  - Byte: offset 0 maps to [7:0].
  - Writes drive mem_wdata from that lane of the latched DataIn.
  - Reads capture mem_rdata into that lane of DataOut on the transfer edge.
  - DataOut is cleared on the edge that leaves IDLE, so unused upper bits read 0.
- Completion: after the transfer edge for byte N-1, the state moves to DONE and MFC is registered to 1.
  - MFC rises on the N*(WAIT_STATES+1)-th rising edge after the edge that sampled MFA.
- DONE:
  - MFC=1 and DataOut is held stable.
  - On any edge with MFA low, the state returns to IDLE and MFC goes to 0.
  - A new request needs MFA to be seen low first; MFA held high keeps the block in DONE with no second access.
- MFA deasserted during ACCESS is ignored. The transfer completes, then DONE lasts exactly one cycle.
- Address wrap: ADDR + idx wraps modulo 2^ADDR_WIDTH; no fault is raised.
- Inputs other than MFA are ignored outside IDLE.
- Reset mid-transfer aborts immediately.
  - Bytes already written stay in RAM.
  - MFC is not asserted for the aborted request.

Optional Feature:
MISALIGN_CHECK_EN
- Defined:
  - Adds output MisAlign (1 bit, reset 0).
  - A halfword request with ADDR[0]=1, or a word request with ADDR[1:0]!=0, performs no RAM access and never raises mem_we.
  - The state goes straight to DONE on the next edge with MFC=1, MisAlign=1 and DataOut=0.
  - MisAlign clears when leaving DONE.
- Undefined: the MisAlign port does not exist; unaligned requests proceed byte-wise with normal wrap.

Test Plan:
1. RAM[0x10..0x13]=DE AD BE EF, word read at 0x10 with WAIT_STATES=0 -> MFC on the 4th edge after MFA is sampled, DataOut=0xDEADBEEF.
2. Word write DataIn=0x12345678 to 0x20 -> RAM[0x20..0x23]=12 34 56 78, exactly 4 mem_we pulses; then a byte read of 0x22 -> DataOut=0x00000056.
3. Halfword read at 0xFF (no misalign check) with RAM[0xFF]=AB, RAM[0x00]=CD -> mem_addr goes 0xFF then 0x00, DataOut=0x0000ABCD.
4. WAIT_STATES=2, byte read -> MFC 3 edges after the sampling edge; MFA held high 5 more cycles -> MFC stays 1 with no further mem_addr activity; MFA low -> MFC=0 next edge.
5. Reset asserted after 2 bytes of a word write -> outputs return to 0 immediately, RAM holds only the first 2 bytes, no MFC pulse.
6. MISALIGN_CHECK_EN defined, word read at 0x02 -> MFC=1 and MisAlign=1 next edge, DataOut=0, mem_we never high.
